oled_frame_refresh: RTL and testbench

Streams a 128x64 monochrome frame buffer to the SSD1306 OLED through the shared IIC write driver after power-up init completes. For each of 8 pages it:
- issues 3 addressing commands: page, column low, column high;
- then issues 128 data bytes, reading each byte from an external frame-buffer RAM.

It sits beside the OLED init sequencer and drives the driver's write-request handshake once init is finished.

---
 rtl/oled_pkg.sv | 21 ++
 rtl/oled_iic_write_req.sv | 52 +++++
 rtl/oled_frame_refresh.sv | 184 ++++++++++++++++++
 tb/tb_oled_frame_refresh.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared constants and the refresh FSM state type for the OLED frame streamer.
package oled_pkg;

    localparam logic [7:0] CTRL_CMD     = 8'h00;
    localparam logic [7:0] CTRL_DATA    = 8'h40;

    localparam logic [7:0] CMD_SET_PAGE = 8'hB0;
    localparam logic [7:0] CMD_COL_LO   = 8'h00;
    localparam logic [7:0] CMD_COL_HI   = 8'h10;

    typedef enum logic [2:0] {
        IDLE,
        CMD_PAGE,
        CMD_COLL,
        CMD_COLH,
        FETCH,
        DATA,
        DONE
    } state_e;

endpackage

// File: rtl/oled_iic_write_req.sv
// Single-byte write handshake towards the shared IIC driver.
// A load pulse captures control/data; req rises one cycle later so the driver
// always sees settled slave/data, and drops on the cycle after write_done.
module oled_iic_write_req
    import oled_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR = 8'h78
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic [7:0]  ctrl_i,
    input  logic [7:0]  data_i,
    input  logic        write_done_i,
    output logic        req_o,
    output logic [15:0] slave_o,
    output logic [7:0]  data_o,
    output logic        ack_o
);

    logic        req_q;
    logic        pend_q;
    logic [15:0] slave_q;
    logic [7:0]  data_q;

    // Capture the byte, raise req a cycle later, hold until the driver completes it.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            req_q   <= 1'b0;
            pend_q  <= 1'b0;
            slave_q <= 16'h0000;
            data_q  <= 8'h00;
        end else if (load_i) begin
            slave_q <= {ctrl_i, SLAVE_ADDR};
            data_q  <= data_i;
            pend_q  <= 1'b1;
            req_q   <= 1'b0;
        end else if (pend_q) begin
            pend_q <= 1'b0;
            req_q  <= 1'b1;
        end else if (req_q && write_done_i) begin
            req_q <= 1'b0;
        end
    end

    // A done pulse only counts while a request is outstanding.
    assign ack_o   = req_q & write_done_i;
    assign req_o   = req_q;
    assign slave_o = slave_q;
    assign data_o  = data_q;

endmodule

// File: rtl/oled_frame_refresh.sv
// Streams the 128x64 frame buffer to the SSD1306 page by page: three addressing
// commands per page followed by one data byte per column.
// Optional build macro OLED_AUTO_REFRESH_EN adds a periodic self-start timer.
//
// state    | meaning
// IDLE     | waiting for a start while init_finish is high
// CMD_PAGE | writing page-select command B0|page
// CMD_COLL | writing column low nibble command 00
// CMD_COLH | writing column high nibble command 10
// FETCH    | frame-buffer read, then capture of the returned byte
// DATA     | writing the captured data byte
// DONE     | one-cycle frame_done, busy low
module oled_frame_refresh
    import oled_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR       = 8'h78,
    parameter int         COLS             = 128,
    parameter int         PAGES            = 8,
    parameter int         REFRESH_INTERVAL = 2500000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        init_finish,
    input  logic        refresh_start,
    output logic        busy,
    output logic        frame_done,
    output logic [9:0]  fb_addr,
    output logic        fb_rd,
    input  logic [7:0]  fb_data,
    output logic        iic_write_req,
    output logic [15:0] iic_slave,
    output logic [7:0]  iic_write_data,
    input  logic        iic_write_done
);

    if (REFRESH_INTERVAL < 2) begin : g_bad_interval
        $error("REFRESH_INTERVAL must be at least 2");
    end

    state_e     state_q, state_d;
    logic [2:0] page_q, page_d;
    logic [6:0] col_q, col_d;
    logic       issued_q, issued_d;
    logic       load;
    logic [7:0] load_ctrl;
    logic [7:0] load_data;
    logic       ack;
    logic       start;

`ifdef OLED_AUTO_REFRESH_EN
    localparam int            TW     = $clog2(REFRESH_INTERVAL);
    localparam logic [TW-1:0] RELOAD = TW'(REFRESH_INTERVAL - 1);

    logic [TW-1:0] tmr_q;

    // Interval timer: held while init is low, reloaded at each frame end, parks at zero.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            tmr_q <= RELOAD;
        end else if (state_q == DONE || !init_finish) begin
            tmr_q <= RELOAD;
        end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end

    assign start = (refresh_start | (tmr_q == '0)) & init_finish;
`else
    assign start = refresh_start & init_finish;
`endif

    // State, page/column counters and the per-state "write already loaded" flag.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            page_q   <= 3'd0;
            col_q    <= 7'd0;
            issued_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            col_q    <= col_d;
            issued_q <= issued_d;
        end
    end

    // Next-state logic: each write state loads once, then waits for the ack.
    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        col_d     = col_q;
        issued_d  = issued_q;
        load      = 1'b0;
        load_ctrl = CTRL_CMD;
        load_data = 8'h00;
        fb_rd     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CMD_PAGE;
                    page_d   = 3'd0;
                    col_d    = 7'd0;
                    issued_d = 1'b0;
                end
            end
            CMD_PAGE, CMD_COLL, CMD_COLH: begin
                if (state_q == CMD_PAGE) begin
                    load_data = CMD_SET_PAGE | {5'd0, page_q};
                end else if (state_q == CMD_COLL) begin
                    load_data = CMD_COL_LO;
                end else begin
                    load_data = CMD_COL_HI;
                end
                if (!issued_q) begin
                    load     = 1'b1;
                    issued_d = 1'b1;
                end else if (ack) begin
                    issued_d = 1'b0;
                    if (state_q == CMD_PAGE) begin
                        state_d = CMD_COLL;
                    end else if (state_q == CMD_COLL) begin
                        state_d = CMD_COLH;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (!issued_q) begin
                    fb_rd    = 1'b1;
                    issued_d = 1'b1;
                end else begin
                    load      = 1'b1;
                    load_ctrl = CTRL_DATA;
                    load_data = fb_data;
                    issued_d  = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (ack) begin
                    if ({25'd0, col_q} == 32'(COLS - 1)) begin
                        col_d = 7'd0;
                        if ({29'd0, page_q} == 32'(PAGES - 1)) begin
                            state_d = DONE;
                        end else begin
                            page_d  = page_q + 3'd1;
                            state_d = CMD_PAGE;
                        end
                    end else begin
                        col_d   = col_q + 7'd1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign frame_done = (state_q == DONE);
    assign fb_addr    = {page_q, col_q};

    oled_iic_write_req #(
        .SLAVE_ADDR(SLAVE_ADDR)
    ) u_write_req (
        .clk_i       (sys_clk),
        .rst_n_i     (rst_n),
        .load_i      (load),
        .ctrl_i      (load_ctrl),
        .data_i      (load_data),
        .write_done_i(iic_write_done),
        .req_o       (iic_write_req),
        .slave_o     (iic_slave),
        .data_o      (iic_write_data),
        .ack_o       (ack)
    );

endmodule

// File: tb/tb_oled_frame_refresh.sv
// Bench for oled_frame_refresh: IIC driver model, synchronous frame-buffer RAM,
// handshake monitor and a frame-level reference of the expected write stream.
module tb_oled_frame_refresh;

    localparam int RI = 5000;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_finish = 1'b0;
    logic        refresh_start = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [9:0]  fb_addr;
    logic        fb_rd;
    logic [7:0]  fb_data = 8'h00;
    logic        iic_write_req;
    logic [15:0] iic_slave;
    logic [7:0]  iic_write_data;
    logic        iic_write_done = 1'b0;

    oled_frame_refresh #(
        .SLAVE_ADDR(8'h78),
        .COLS(128),
        .PAGES(8),
        .REFRESH_INTERVAL(RI)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .init_finish(init_finish),
        .refresh_start(refresh_start),
        .busy(busy),
        .frame_done(frame_done),
        .fb_addr(fb_addr),
        .fb_rd(fb_rd),
        .fb_data(fb_data),
        .iic_write_req(iic_write_req),
        .iic_slave(iic_slave),
        .iic_write_data(iic_write_data),
        .iic_write_done(iic_write_done)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  mem [1024];
    logic [23:0] got_q [$];
    logic [23:0] exp_q [$];

    int drv_fixed = 4;
    int drv_delay = 4;
    int drv_age = 0;
    bit inj_done = 1'b0;

    int fd_count = 0;
    int cyc = 0;
    int last_fd_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the whole frame as a list of {slave, byte} writes.
    function automatic void build_exp();
        exp_q.delete();
        for (int p = 0; p < 8; p++) begin
            exp_q.push_back({16'h0078, 8'hB0 + 8'(p)});
            exp_q.push_back({16'h0078, 8'h00});
            exp_q.push_back({16'h0078, 8'h10});
            for (int c = 0; c < 128; c++) begin
                exp_q.push_back({16'h4078, mem[p * 128 + c]});
            end
        end
    endfunction

    function automatic int count_mismatch();
        int n = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) n++;
        end
        return n;
    endfunction

    // IIC driver model: acks after drv_delay cycles of req, records each completed write.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            iic_write_done = 1'b0;
            if (!iic_write_req) begin
                drv_age = 0;
                if (inj_done) begin
                    iic_write_done = 1'b1;
                    inj_done = 1'b0;
                end
            end else begin
                drv_age++;
                if (drv_age >= drv_delay) begin
                    iic_write_done = 1'b1;
                    got_q.push_back({iic_slave, iic_write_data});
                    drv_age = 0;
                    drv_delay = (drv_fixed != 0) ? drv_fixed : int'($urandom_range(1, 6));
                end
            end
        end
    end

    // Frame-buffer RAM: data for a read strobe appears in the following cycle.
    initial begin
        logic       rd_pend;
        logic [9:0] rd_addr;
        forever begin
            @(negedge sys_clk);
            rd_pend = fb_rd;
            rd_addr = fb_addr;
            @(posedge sys_clk);
            #1;
            if (rd_pend) fb_data = mem[rd_addr];
        end
    end

    // Handshake monitor.
    logic        m_req = 1'b0;
    logic        m_ack = 1'b0;
    logic        m_fd = 1'b0;
    logic [15:0] m_slave = 16'h0;
    logic [7:0]  m_data = 8'h0;

    always @(negedge sys_clk) begin
        cyc++;
        if (rst_n) begin
            if (iic_write_req) begin
                check("slave_stable", {16'h0, iic_slave}, {16'h0, m_slave});
                check("data_stable", {24'h0, iic_write_data}, {24'h0, m_data});
            end
            if (m_ack) check("req_drop_after_done", {31'h0, iic_write_req}, 32'h0);
            if (frame_done) begin
                check("frame_done_width", {31'h0, m_fd}, 32'h0);
                check("busy_low_at_done", {31'h0, busy}, 32'h0);
            end
        end
        if (frame_done) begin
            fd_count++;
            last_fd_cyc = cyc;
        end
        m_req   = iic_write_req;
        m_ack   = iic_write_req & iic_write_done;
        m_fd    = frame_done;
        m_slave = iic_slave;
        m_data  = iic_write_data;
    end

    task automatic pulse_start();
        @(negedge sys_clk);
        refresh_start = 1'b1;
        @(negedge sys_clk);
        refresh_start = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int fd0);
        int n = 0;
        while (fd_count == fd0 && n < 30000) begin
            @(negedge sys_clk);
            n++;
        end
        check({tag, "_completed"}, {31'h0, fd_count != fd0}, 32'h1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_frame_done"}, {31'h0, frame_done}, 32'h0);
        check({tag, "_fb_rd"}, {31'h0, fb_rd}, 32'h0);
        check({tag, "_req"}, {31'h0, iic_write_req}, 32'h0);
        check({tag, "_fb_addr"}, {22'h0, fb_addr}, 32'h0);
        check({tag, "_slave"}, {16'h0, iic_slave}, 32'h0);
        check({tag, "_wdata"}, {24'h0, iic_write_data}, 32'h0);
    endtask

    initial begin
        int fd0;
        int n_bad;
        int n;

        for (int i = 0; i < 1024; i++) mem[i] = i[7:0];

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Start ignored while init is low
        pulse_start();
        n_bad = 0;
        repeat (100) begin
            @(negedge sys_clk);
            if (busy || iic_write_req) n_bad++;
        end
        check("noinit_ignored", n_bad, 0);

        // Full frame, fb = addr[7:0], fixed 4-cycle ack
        init_finish = 1'b1;
        got_q.delete();
        build_exp();
        fd0 = fd_count;
        pulse_start();
        check("busy_after_start", {31'h0, busy}, 32'h1);
        wait_frame("f1", fd0);
        check("f1_count", got_q.size(), 1048);
        check("f1_w0", got_q[0], {16'h0078, 8'hB0});
        check("f1_w1", got_q[1], {16'h0078, 8'h00});
        check("f1_w2", got_q[2], {16'h0078, 8'h10});
        check("f1_w3", got_q[3], {16'h4078, 8'h00});
        check("f1_page7_hdr", got_q[917], {16'h0078, 8'hB7});
        check("f1_last", got_q[1047], {16'h4078, 8'hFF});
        check("f1_stream", count_mismatch(), 0);
        repeat (5) @(negedge sys_clk);
        check("f1_one_done", fd_count - fd0, 1);
        check("f1_busy_after", {31'h0, busy}, 32'h0);

        // Random data and ack latency; stray start/done and init drop mid-frame
        drv_fixed = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        build_exp();
        got_q.delete();
        fd0 = fd_count;
        pulse_start();
        repeat (1500) @(negedge sys_clk);
        pulse_start();
        repeat (300) @(negedge sys_clk);
        inj_done = 1'b1;
        repeat (500) @(negedge sys_clk);
        inj_done = 1'b1;
        init_finish = 1'b0;
        repeat (2000) @(negedge sys_clk);
        check("f2_busy_mid", {31'h0, busy}, 32'h1);
        wait_frame("f2", fd0);
        init_finish = 1'b1;
        check("f2_count", got_q.size(), 1048);
        check("f2_stream", count_mismatch(), 0);
        repeat (5) @(negedge sys_clk);
        check("f2_one_done", fd_count - fd0, 1);

        // Reset for one cycle during page 3 data
        got_q.delete();
        fd0 = fd_count;
        pulse_start();
        n = 0;
        while (got_q.size() < 3 * 131 + 8 && n < 20000) begin
            @(negedge sys_clk);
            n++;
        end
        check("rst_reached_page3", {31'h0, got_q.size() >= 3 * 131 + 8}, 32'h1);
        @(negedge sys_clk);
        rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        check_zero_outputs("midrst");
        repeat (50) @(negedge sys_clk);
        check("midrst_no_done", fd_count - fd0, 0);
        check("midrst_idle", {30'h0, busy, iic_write_req}, 32'h0);
        got_q.delete();
        build_exp();
        fd0 = fd_count;
        pulse_start();
        wait_frame("f3", fd0);
        check("f3_first", got_q[0], {16'h0078, 8'hB0});
        check("f3_count", got_q.size(), 1048);
        check("f3_stream", count_mismatch(), 0);

`ifdef OLED_AUTO_REFRESH_EN
        // Self-start one interval after the previous frame_done
        got_q.delete();
        fd0 = fd_count;
        n = 0;
        while (!busy && n < RI + 2000) begin
            @(negedge sys_clk);
            n++;
        end
        check("auto_started", {31'h0, busy}, 32'h1);
        check("auto_delay", {31'h0, (cyc - last_fd_cyc) >= RI && (cyc - last_fd_cyc) <= RI + 1}, 32'h1);
        wait_frame("auto", fd0);
        check("auto_count", got_q.size(), 1048);
        check("auto_stream", count_mismatch(), 0);
`else
        n_bad = 0;
        repeat (300) begin
            @(negedge sys_clk);
            if (busy || iic_write_req) n_bad++;
        end
        check("no_self_start", n_bad, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
